// File: rtl/global_constants.sv
// System-wide sizing constants shared across the motion_system blocks.
package global_constants;
  localparam int unsigned RX_BYTES       = 6;
  localparam int unsigned TX_BYTES       = 8;
  localparam int unsigned TIMEOUT_CYCLES = 50000;
endpackage

// File: rtl/types.sv
// Shared types: byte alias, register-bank command codes and the uP packet FSM states.
package types;
  typedef logic [7:0] byte_t;

  localparam byte_t READ_REGISTER_CMD  = 8'd0;
  localparam byte_t WRITE_REGISTER_CMD = 8'd1;

  typedef enum logic [3:0] {
    IDLE,
    RX_WAIT_H1,
    RX_WAIT_H1_LOW,
    EXEC,
    BUS_WAIT,
    TX_SETUP,
    TX_WAIT_H1,
    TX_WAIT_H1_LOW,
    ACK
  } up_state_t;
endpackage

// File: rtl/synchroniser.sv
// Purpose: two-flop synchroniser for asynchronous level inputs.
// Latency: 2 clocks. Backpressure: none, free-running.
module synchroniser #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/up_packet_interface.sv
// Purpose: uP byte handshake engine; 6-byte command in, one bus request, 8-byte reply out.
// Latency: 3 clocks from host strobe to uP_handshake_2; backpressure: waits on host strobes and bus_done.
// Optional UP_TIMEOUT_EN adds a host-stall timeout with sticky timeout_err.
module up_packet_interface
  import types::*;
  import global_constants::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        async_uP_start,
  input  logic        async_uP_handshake_1,
  input  logic        async_uP_RW,
  input  logic [7:0]  uP_data_in,
  output logic [7:0]  uP_data_out,
  output logic        uP_data_oe,
  output logic        uP_handshake_2,
  output logic        uP_ack,
  output logic        bus_req,
  output logic [7:0]  bus_cmd,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_done,
  input  logic [31:0] bus_rdata,
  input  logic [31:0] bus_status,
  output logic        timeout_err
);
  localparam logic [3:0] RX_LAST = 4'(RX_BYTES);
  localparam logic [3:0] TX_LAST = 4'(TX_BYTES);

  logic start_s, h1_s, rw_s, start_q, start_edge;
  up_state_t state, state_nxt;
  logic [3:0] idx, idx_nxt, idx_inc;
  byte_t [RX_BYTES-1:0] rx_pkt;
  logic [63:0] tx_shift;
  logic setup_seen, setup_seen_nxt;
  logic hs2_nxt, ack_nxt, req_nxt;
  logic rx_we, tx_load, tx_shift_en;

  synchroniser #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({async_uP_start, async_uP_handshake_1, async_uP_RW}),
    .q     ({start_s, h1_s, rw_s})
  );

  assign start_edge = start_s & ~start_q;
  assign idx_inc    = idx + 4'd1;

`ifdef UP_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        tmo_fire, tmo_err;

  assign tmo_fire = (state inside {RX_WAIT_H1, RX_WAIT_H1_LOW, TX_SETUP, TX_WAIT_H1,
                                   TX_WAIT_H1_LOW, ACK})
                    && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    setup_seen_nxt = 1'b0;
    hs2_nxt        = uP_handshake_2;
    ack_nxt        = uP_ack;
    req_nxt        = 1'b0;
    rx_we          = 1'b0;
    tx_load        = 1'b0;
    tx_shift_en    = 1'b0;
    unique case (state)
      IDLE: if (start_edge) begin
        idx_nxt   = '0;
        state_nxt = RX_WAIT_H1;
      end
      RX_WAIT_H1: if (h1_s && rw_s) begin
        rx_we     = 1'b1;
        hs2_nxt   = 1'b1;
        state_nxt = RX_WAIT_H1_LOW;
      end
      RX_WAIT_H1_LOW: if (!h1_s) begin
        hs2_nxt   = 1'b0;
        idx_nxt   = idx_inc;
        state_nxt = (idx_inc == RX_LAST) ? EXEC : RX_WAIT_H1;
      end
      EXEC: begin
        req_nxt   = 1'b1;
        state_nxt = BUS_WAIT;
      end
      BUS_WAIT: if (bus_done) begin
        tx_load   = 1'b1;
        idx_nxt   = '0;
        state_nxt = TX_SETUP;
      end
      // Bus must be released for two consecutive samples before we strobe.
      TX_SETUP: begin
        setup_seen_nxt = !h1_s && !rw_s;
        if (setup_seen && setup_seen_nxt) begin
          setup_seen_nxt = 1'b0;
          hs2_nxt        = 1'b1;
          state_nxt      = TX_WAIT_H1;
        end
      end
      TX_WAIT_H1: if (h1_s) begin
        hs2_nxt   = 1'b0;
        state_nxt = TX_WAIT_H1_LOW;
      end
      TX_WAIT_H1_LOW: if (!h1_s) begin
        idx_nxt     = idx_inc;
        tx_shift_en = 1'b1;
        if (idx_inc == TX_LAST) begin
          ack_nxt   = 1'b1;
          state_nxt = ACK;
        end else begin
          state_nxt = TX_SETUP;
        end
      end
      ACK: if (!start_s) begin
        ack_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef UP_TIMEOUT_EN
    if (tmo_fire) begin
      state_nxt      = IDLE;
      hs2_nxt        = 1'b0;
      ack_nxt        = 1'b0;
      setup_seen_nxt = 1'b0;
      req_nxt        = 1'b0;
      rx_we          = 1'b0;
      tx_load        = 1'b0;
      tx_shift_en    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      start_q        <= 1'b0;
      setup_seen     <= 1'b0;
      uP_handshake_2 <= 1'b0;
      uP_ack         <= 1'b0;
      bus_req        <= 1'b0;
      tx_shift       <= '0;
      rx_pkt         <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      start_q        <= start_s;
      setup_seen     <= setup_seen_nxt;
      uP_handshake_2 <= hs2_nxt;
      uP_ack         <= ack_nxt;
      bus_req        <= req_nxt;
      if (tx_load)
        tx_shift <= {bus_status, bus_rdata};
      else if (tx_shift_en)
        tx_shift <= {8'h00, tx_shift[63:8]};
      if (rx_we)
        rx_pkt[idx[2:0]] <= uP_data_in;
    end
  end

`ifdef UP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      tmo_err   <= 1'b0;
    end else begin
      stall_cnt <= (state_nxt != state) ? 16'd0 : stall_cnt + 16'd1;
      if (tmo_fire)
        tmo_err <= 1'b1;
      else if (state == IDLE && start_edge)
        tmo_err <= 1'b0;
    end
  end
  assign timeout_err = tmo_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign uP_data_out = tx_shift[7:0];
  assign uP_data_oe  = (state inside {TX_SETUP, TX_WAIT_H1, TX_WAIT_H1_LOW}) && !rw_s;
  assign bus_cmd     = rx_pkt[0];
  assign bus_addr    = rx_pkt[1];
  assign bus_wdata   = {rx_pkt[5], rx_pkt[4], rx_pkt[3], rx_pkt[2]};
endmodule

// File: tb/tb_up_packet_interface.sv
// Directed bench for up_packet_interface: host handshake model plus a register-bank responder.
module tb_up_packet_interface;
  logic        clk = 1'b0;
  logic        reset;
  logic        async_uP_start, async_uP_handshake_1, async_uP_RW;
  logic [7:0]  uP_data_in, uP_data_out;
  logic        uP_data_oe, uP_handshake_2, uP_ack;
  logic        bus_req, bus_done, timeout_err;
  logic [7:0]  bus_cmd, bus_addr;
  logic [31:0] bus_wdata, bus_rdata, bus_status;

  int tests = 0;
  int fails = 0;
  int req_count = 0;
  logic [31:0] cfg_rdata, cfg_status;
  int          cfg_lat;
  logic [7:0]  cap_cmd, cap_addr;
  logic [31:0] cap_wdata;

  always #10 clk = ~clk;

  up_packet_interface dut (
    .clk                  (clk),
    .reset                (reset),
    .async_uP_start       (async_uP_start),
    .async_uP_handshake_1 (async_uP_handshake_1),
    .async_uP_RW          (async_uP_RW),
    .uP_data_in           (uP_data_in),
    .uP_data_out          (uP_data_out),
    .uP_data_oe           (uP_data_oe),
    .uP_handshake_2       (uP_handshake_2),
    .uP_ack               (uP_ack),
    .bus_req              (bus_req),
    .bus_cmd              (bus_cmd),
    .bus_addr             (bus_addr),
    .bus_wdata            (bus_wdata),
    .bus_done             (bus_done),
    .bus_rdata            (bus_rdata),
    .bus_status           (bus_status),
    .timeout_err          (timeout_err)
  );

  // Counts every cycle bus_req is high, so a stretched pulse shows up as an extra request.
  initial forever begin
    @(posedge clk); #1;
    if (bus_req === 1'b1) begin
      req_count++;
      cap_cmd   = bus_cmd;
      cap_addr  = bus_addr;
      cap_wdata = bus_wdata;
    end
  end

  initial begin
    bus_done   = 1'b0;
    bus_rdata  = '0;
    bus_status = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_req === 1'b1) begin
        if (cfg_lat > 0) begin
          repeat (cfg_lat) @(posedge clk);
          #1;
        end
        bus_rdata  = cfg_rdata;
        bus_status = cfg_status;
        bus_done   = 1'b1;
        @(posedge clk); #1;
        bus_done   = 1'b0;
        bus_rdata  = 32'hDEAD_BEEF;
        bus_status = 32'hBAD0_BAD0;
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hs2(input logic v, input string tag);
    int n = 0;
    while (uP_handshake_2 !== v && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(uP_handshake_2), 64'(v));
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (uP_ack !== v && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(uP_ack), 64'(v));
  endtask

  task automatic host_write(input logic [7:0] b);
    wait_hs2(1'b0, "rx_hs2_low_before");
    uP_data_in           = b;
    async_uP_RW          = 1'b1;
    async_uP_handshake_1 = 1'b1;
    wait_hs2(1'b1, "rx_hs2_rise");
    chk("rx_oe_off", 64'(uP_data_oe), 64'd0);
    async_uP_handshake_1 = 1'b0;
    uP_data_in           = ~b;
    wait_hs2(1'b0, "rx_hs2_fall");
  endtask

  task automatic host_read(input logic [7:0] exp, input int i);
    async_uP_RW          = 1'b0;
    async_uP_handshake_1 = 1'b0;
    wait_hs2(1'b1, "tx_hs2_rise");
    chk($sformatf("tx_byte%0d", i), 64'(uP_data_out), 64'(exp));
    chk("tx_oe_on", 64'(uP_data_oe), 64'd1);
    async_uP_handshake_1 = 1'b1;
    wait_hs2(1'b0, "tx_hs2_fall");
    async_uP_handshake_1 = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input logic [31:0] status, input int lat,
                         input int rw_hold);
    int base;
    logic [63:0] reply;
    logic oe_seen, hs_seen;
    cfg_rdata      = rdata;
    cfg_status     = status;
    cfg_lat        = lat;
    base           = req_count;
    reply          = {status, rdata};
    async_uP_start = 1'b1;
    host_write(cmd);
    host_write(addr);
    for (int i = 0; i < 4; i++) host_write(data[8*i +: 8]);
    @(posedge clk); #1;
    chk("bus_req_timing", 64'(bus_req), 64'd1);
    oe_seen = 1'b0;
    hs_seen = 1'b0;
    for (int i = 0; i < rw_hold; i++) begin
      @(posedge clk); #1;
      if (uP_data_oe !== 1'b0) oe_seen = 1'b1;
      if (uP_handshake_2 !== 1'b0) hs_seen = 1'b1;
    end
    if (rw_hold > 0) begin
      chk("contention_oe", 64'(oe_seen), 64'd0);
      chk("contention_hs2", 64'(hs_seen), 64'd0);
    end
    for (int i = 0; i < 8; i++) host_read(reply[8*i +: 8], i);
    chk("req_count", 64'(req_count), 64'(base + 1));
    chk("bus_cmd", 64'(cap_cmd), 64'(cmd));
    chk("bus_addr", 64'(cap_addr), 64'(addr));
    chk("bus_wdata", 64'(cap_wdata), 64'(data));
    wait_ack(1'b1, "ack_rise");
    async_uP_start = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  initial begin
    int base;
    reset                = 1'b1;
    async_uP_start       = 1'b0;
    async_uP_handshake_1 = 1'b0;
    async_uP_RW          = 1'b0;
    uP_data_in           = 8'h00;
    cfg_rdata            = '0;
    cfg_status           = '0;
    cfg_lat              = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_hs2", 64'(uP_handshake_2), 64'd0);
    chk("rst_ack", 64'(uP_ack), 64'd0);
    chk("rst_oe", 64'(uP_data_oe), 64'd0);
    chk("rst_dout", 64'(uP_data_out), 64'd0);
    chk("rst_req", 64'(bus_req), 64'd0);
    chk("rst_cmd", 64'(bus_cmd), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_wdata", 64'(bus_wdata), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Write transaction, register bank answers in the cycle after the request.
    run_txn(8'h01, 8'h21, 32'd100, 32'h0000_0064, 32'h0, 0, 0);
    chk("wdata_hold", 64'(bus_wdata), 64'h64);

    // Byte-order check with a slower register bank.
    run_txn(8'h00, 8'h05, 32'hA1B2_C3D4, 32'h1122_3344, 32'h0000_0080, 5, 0);

    // Back-to-back transactions with distinct payloads and unknown commands.
    base = req_count;
    for (int k = 0; k < 4; k++) begin
      #50;
      run_txn(8'(k + 2), 8'(8'h10 + k), 32'h0102_0304 + 32'(k) * 32'h1111_1111,
              32'hF0E0_D0C0 ^ 32'(k), 32'(k) << 8, k, 0);
    end
    chk("b2b_req_count", 64'(req_count), 64'(base + 4));

    // Reset in the middle of RX byte 3.
    base           = req_count;
    async_uP_start = 1'b1;
    host_write(8'h01);
    host_write(8'h02);
    host_write(8'h03);
    uP_data_in           = 8'h44;
    async_uP_RW          = 1'b1;
    async_uP_handshake_1 = 1'b1;
    wait_hs2(1'b1, "midrst_hs2_rise");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_hs2", 64'(uP_handshake_2), 64'd0);
    chk("midrst_addr", 64'(bus_addr), 64'd0);
    chk("midrst_wdata", 64'(bus_wdata), 64'd0);
    async_uP_start       = 1'b0;
    async_uP_handshake_1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_req", 64'(req_count), 64'(base));
    run_txn(8'h01, 8'h33, 32'h5566_7788, 32'hCAFE_F00D, 32'h0000_0001, 2, 0);

    // Host keeps driving the bus into the reply phase.
    run_txn(8'h00, 8'h07, 32'h0BAD_CAFE, 32'h8765_4321, 32'h0000_0002, 1, 40);

`ifdef UP_TIMEOUT_EN
    async_uP_start = 1'b1;
    host_write(8'h01);
    host_write(8'h09);
    uP_data_in           = 8'h77;
    async_uP_RW          = 1'b1;
    async_uP_handshake_1 = 1'b1;
    wait_hs2(1'b1, "tmo_hs2_rise");
    repeat (50050) @(posedge clk);
    #1;
    chk("tmo_flag", 64'(timeout_err), 64'd1);
    chk("tmo_hs2", 64'(uP_handshake_2), 64'd0);
    chk("tmo_oe", 64'(uP_data_oe), 64'd0);
    async_uP_handshake_1 = 1'b0;
    async_uP_start       = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    async_uP_start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("tmo_clear", 64'(timeout_err), 64'd0);
    run_txn(8'h01, 8'h0A, 32'h1234_5678, 32'h0000_00AA, 32'h0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
